bram_fifo_read_ctrl: RTL and testbench
======================================

BRAM_FIFO_READ_CTRL -- requirements
Module: bram_fifo_read_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the BRAM FIFO read data and the output stream.
REQ-002 Parameter RD_LATENCY, default 3: cycles from a fifo_pop assertion to valid data on fifo_rd_data; legal range 1..8.
REQ-003 Parameter BUF_DEPTH, default 4: output buffer entries; legal values are BUF_DEPTH >= RD_LATENCY+1.
REQ-004 Port core_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port enable, input, 1 bit: permits new pops while high.
REQ-007 Port flush, input, 1 bit: discards buffered and in-flight data.
REQ-008 Port fifo_empty, input, 1 bit: FIFO empty status, updated one cycle after each pop.
REQ-009 Port fifo_pop, output, 1 bit: FIFO pop strobe, registered.
REQ-010 Port fifo_rd_data, input, DATA_WIDTH bits: FIFO read data.
REQ-011 Port out_valid, output, 1 bit: output stream valid.
REQ-012 Port out_ready, input, 1 bit: output stream ready.
REQ-013 Port out_data, output, DATA_WIDTH bits: output stream data.
REQ-014 Port busy, output, 1 bit: high when the state is not IDLE or the buffer is non-empty.

Function
REQ-015 States SHALL be IDLE, RUN, DRAIN and FLUSH.
REQ-016 Transitions SHALL be:
- IDLE->RUN when enable=1.
- RUN->DRAIN when enable=0.
- DRAIN->RUN when enable=1.
- DRAIN->IDLE when inflight=0.
- Any state->FLUSH when flush=1, with priority over all other transitions.
- FLUSH->IDLE when flush=0 and inflight=0.
REQ-017 fifo_pop SHALL be asserted for a cycle only when all hold: state is RUN, fifo_empty=0, fifo_pop was 0 in the previous cycle, and buf_count+inflight < BUF_DEPTH.
- The previous-cycle condition keeps issue to at most one pop every two cycles, so fifo_empty is never stale.
REQ-018 An RD_LATENCY-deep valid shift register SHALL track every pop; inflight is its population count, 0..RD_LATENCY.
REQ-019 When a tracked pop exits the shift register, fifo_rd_data SHALL be written into the buffer tail that same cycle, unless the entry is marked discard.
REQ-020 The buffer SHALL be first-word-fall-through:
- out_valid=1 whenever buf_count>0.
- out_data = head entry.
- The head is removed on out_valid && out_ready.
REQ-021 A simultaneous buffer write and head removal SHALL leave buf_count unchanged and preserve order; buffer pointers wrap modulo BUF_DEPTH.
REQ-022 The credit rule in REQ-017 SHALL guarantee that the buffer never overflows; an overflow is a design error, flagged by an assertion in simulation.
REQ-023 flush=1 SHALL, in the same cycle, do all of the following:
- Clear buf_count to 0 and deassert out_valid on the next cycle.
- Block new pops.
- Mark every in-flight entry as discard.
REQ-024 Entries popped before a flush SHALL never appear on out_data after it.
REQ-025 Latency from a pop to out_valid on an empty buffer SHALL be RD_LATENCY+1 cycles.
REQ-026 Deasserting enable SHALL never drop data: in-flight words land in the buffer and remain available until consumed.

Reset
REQ-027 On resetn=0 the block SHALL asynchronously force all of the following:
- state=IDLE.
- fifo_pop=0, out_valid=0, out_data=0, busy=0.
- buf_count=0, inflight=0.
- Pointers=0.
REQ-028 A reset mid-operation SHALL discard all buffered and in-flight data; the first pop after release SHALL occur no earlier than 2 cycles after resetn rises.

Configuration
REQ-029 With macro BRAM_FIFO_READ_CTRL_STATS_EN defined, the block SHALL add output port words_out (32 bits):
- Increments on each out_valid && out_ready.
- Wraps at 2^32.
- Reset to 0.
- Unaffected by flush.
REQ-030 Without BRAM_FIFO_READ_CTRL_STATS_EN, port words_out and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Scenario, basic stream:
- Stimulus: FIFO holds 0xA,0xB,0xC; enable=1; out_ready=1.
- Required response: out_data sequence 0xA,0xB,0xC; first out_valid 4 cycles after the first pop (RD_LATENCY=3).
REQ-032 Scenario, back-pressure:
- Stimulus: out_ready=0; FIFO holds 10 words.
- Required response: pops stop with buf_count+inflight=4, out_valid=1, no loss; after out_ready=1, all 10 words arrive in order.
REQ-033 Scenario, flush:
- Stimulus: flush for 1 cycle with 2 words in flight and 2 buffered.
- Required response: out_valid=0 next cycle; none of the 4 words are ever output; state returns to IDLE after inflight=0.
REQ-034 Scenario, enable drop:
- Stimulus: enable=0 one cycle after a pop.
- Required response: state DRAIN; the popped word is delivered; state reaches IDLE; no further pops.
REQ-035 Scenario, reset mid-stream:
- Stimulus: resetn=0 with 3 words buffered.
- Required response: out_valid=0 immediately; busy=0; words_out=0 (STATS_EN build).
REQ-036 Scenario, empty FIFO:
- Stimulus: fifo_empty=1 with enable=1 for 20 cycles.
- Required response: fifo_pop stays 0, state RUN, out_valid stays 0.

Source files
------------

// File: rtl/bram_fifo_read_ctrl_if.sv
// Handshake bundle for the BRAM FIFO read controller: FIFO read port on one side,
// first-word-fall-through output stream on the other.
interface bram_fifo_read_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        input  fifo_empty, fifo_rd_data, out_ready,
        output fifo_pop, out_valid, out_data
    );

    modport slave (
        output fifo_empty, fifo_rd_data, out_ready,
        input  fifo_pop, out_valid, out_data
    );
endinterface

// File: rtl/bram_fifo_read_ctrl.sv
// Pops a fixed-latency BRAM FIFO into a small FWFT buffer with credit-based issue and flush.
// Optional words_out counter is built when BRAM_FIFO_READ_CTRL_STATS_EN is defined.
module bram_fifo_read_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 3,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                  core_clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  flush,
    output logic                  busy,
`ifdef BRAM_FIFO_READ_CTRL_STATS_EN
    output logic [31:0]           words_out,
`endif
    bram_fifo_read_ctrl_if.master bus
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int INF_W = $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;

    state_t                state;
    logic [RD_LATENCY-1:0] vld_p;
    logic [RD_LATENCY-1:0] dis_p;
    logic [INF_W-1:0]      inflight;
    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      buf_count;
    logic                  land;
    logic                  take;
    logic                  pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == BUF_DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int k = 0; k < RD_LATENCY; k++) begin
            inflight = inflight + INF_W'(vld_p[k]);
        end
    end

    assign land = vld_p[RD_LATENCY-1] && !dis_p[RD_LATENCY-1] && !flush;
    assign take = bus.out_valid && bus.out_ready;

    // A pop held in fifo_pop is excluded by the spacing rule, so buf_count+inflight is the full credit use.
    assign pop_ok = (state == RUN) && enable && !flush && !bus.fifo_empty && !bus.fifo_pop &&
                    ((int'(buf_count) + int'(inflight)) < BUF_DEPTH);

    assign bus.out_valid = (buf_count != '0);
    assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;
    assign busy          = (state != IDLE) || (buf_count != '0);

    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            bus.fifo_pop <= 1'b0;
            vld_p        <= '0;
            dis_p        <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            buf_count    <= '0;
        end else begin
            bus.fifo_pop <= pop_ok;

            // read-latency tracker: every live entry is tagged for discard while flush is high
            vld_p[0] <= bus.fifo_pop;
            dis_p[0] <= flush;
            for (int k = 1; k < RD_LATENCY; k++) begin
                vld_p[k] <= vld_p[k-1];
                dis_p[k] <= dis_p[k-1] | flush;
            end

            if (flush) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                buf_count <= '0;
            end else begin
                if (land) wr_ptr <= ptr_inc(wr_ptr);
                if (take) rd_ptr <= ptr_inc(rd_ptr);
                buf_count <= buf_count + CNT_W'(land) - CNT_W'(take);
            end

            if (flush) begin
                state <= FLUSH;
            end else begin
                case (state)
                    IDLE:    if (enable) state <= RUN;
                    RUN:     if (!enable) state <= DRAIN;
                    DRAIN:   if (enable) state <= RUN;
                             else if (inflight == '0) state <= IDLE;
                    FLUSH:   if (inflight == '0) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // buffer storage holds data only; validity comes from buf_count
    always_ff @(posedge core_clk) begin
        if (land) mem[wr_ptr] <= bus.fifo_rd_data;
    end

`ifdef BRAM_FIFO_READ_CTRL_STATS_EN
    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
            words_out <= '0;
        end else if (take) begin
            words_out <= words_out + 32'd1;
        end
    end
`endif

    overflow_chk: assert property (@(posedge core_clk) disable iff (!resetn)
        !(land && !take && (int'(buf_count) == BUF_DEPTH)));

endmodule

// File: tb/tb_bram_fifo_read_ctrl.sv
// Directed bench for bram_fifo_read_ctrl with a 3-cycle-latency BRAM FIFO model.
module tb_bram_fifo_read_ctrl;
    localparam int DW = 32;

    logic core_clk = 1'b0;
    logic resetn;
    logic enable;
    logic flush;
    logic busy;
`ifdef BRAM_FIFO_READ_CTRL_STATS_EN
    logic [31:0] words_out;
`endif

    bram_fifo_read_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    bram_fifo_read_ctrl #(
        .DATA_WIDTH(DW),
        .RD_LATENCY(3),
        .BUF_DEPTH (4)
    ) dut (
        .core_clk (core_clk),
        .resetn   (resetn),
        .enable   (enable),
        .flush    (flush),
        .busy     (busy),
`ifdef BRAM_FIFO_READ_CTRL_STATS_EN
        .words_out(words_out),
`endif
        .bus      (bus)
    );

    always #5 core_clk = ~core_clk;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] rx[$];
    logic [DW-1:0] p0 = '0;
    logic [DW-1:0] p1 = '0;
    int pops = 0;
    int n_checks = 0;
    int n_errors = 0;

    // FIFO model: pop seen at edge t+1, data on fifo_rd_data from edge t+3
    always @(posedge core_clk) begin
        if (bus.fifo_pop && fifo_q.size() > 0) p0 <= fifo_q.pop_front();
        p1               <= p0;
        bus.fifo_rd_data <= p1;
        bus.fifo_empty   <= (fifo_q.size() == 0);
    end

    always @(negedge core_clk) begin
        if (resetn) begin
            if (bus.fifo_pop) pops++;
            if (bus.out_valid && bus.out_ready) rx.push_back(bus.out_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge core_clk);
        #1;
    endtask

    task automatic load(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + 32'(i));
    endtask

    initial begin
        int n;
        int k;
        int rx_base;
        int pop_base;
        int vseen;

        resetn = 1'b0;
        enable = 1'b0;
        flush  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge core_clk);
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_fifo_pop",  32'(bus.fifo_pop),  32'd0);
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_out_data",  bus.out_data,       32'd0);
`ifdef BRAM_FIFO_READ_CTRL_STATS_EN
        chk("rst_words_out", words_out,          32'd0);
`endif
        resetn = 1'b1;
        step(2);

        // basic stream
        rx_base = rx.size(); pop_base = pops;
        load(3, 32'hA);
        bus.out_ready = 1'b1;
        enable = 1'b1;
        for (n = 0; n < 20 && !bus.fifo_pop; n++) @(negedge core_clk);
        for (n = 0; n < 20 && !bus.out_valid; n++) @(negedge core_clk);
        chk("s1_latency", 32'(n), 32'd4);
        step(20);
        chk("s1_count", 32'(rx.size() - rx_base), 32'd3);
        chk("s1_w0", (rx.size() > rx_base)     ? rx[rx_base]     : 32'hFFFF_FFFF, 32'hA);
        chk("s1_w1", (rx.size() > rx_base + 1) ? rx[rx_base + 1] : 32'hFFFF_FFFF, 32'hB);
        chk("s1_w2", (rx.size() > rx_base + 2) ? rx[rx_base + 2] : 32'hFFFF_FFFF, 32'hC);
        chk("s1_pops", 32'(pops - pop_base), 32'd3);
        enable = 1'b0;
        step(5);
        chk("s1_idle_busy", 32'(busy), 32'd0);

        // back-pressure
        rx_base = rx.size(); pop_base = pops;
        bus.out_ready = 1'b0;
        load(10, 32'h100);
        enable = 1'b1;
        step(30);
        chk("s2_pops_held", 32'(pops - pop_base), 32'd4);
        chk("s2_valid",     32'(bus.out_valid),   32'd1);
        chk("s2_no_out",    32'(rx.size() - rx_base), 32'd0);
        bus.out_ready = 1'b1;
        step(60);
        chk("s2_count", 32'(rx.size() - rx_base), 32'd10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("s2_w%0d", i),
                (rx.size() > rx_base + i) ? rx[rx_base + i] : 32'hFFFF_FFFF, 32'h100 + 32'(i));
        end
        chk("s2_pops_total", 32'(pops - pop_base), 32'd10);
        enable = 1'b0;
        step(5);

        // flush with 2 buffered and 2 in flight
        rx_base = rx.size();
        bus.out_ready = 1'b0;
        load(4, 32'h300);
        enable = 1'b1;
        k = 0;
        for (n = 0; n < 40 && k < 4; n++) begin
            @(negedge core_clk);
            if (bus.fifo_pop) k++;
        end
        chk("s3_four_pops", 32'(k), 32'd4);
        step(1);
        chk("s3_pre_buf",      32'(dut.buf_count), 32'd2);
        chk("s3_pre_inflight", 32'(dut.inflight),  32'd2);
        flush  = 1'b1;
        enable = 1'b0;
        step(1);
        flush = 1'b0;
        chk("s3_valid_next", 32'(bus.out_valid), 32'd0);
        chk("s3_state_flush", 32'(dut.state), 32'd3);
        bus.out_ready = 1'b1;
        step(20);
        chk("s3_none_out", 32'(rx.size() - rx_base), 32'd0);
        chk("s3_state_idle", 32'(dut.state), 32'd0);
        chk("s3_busy", 32'(busy), 32'd0);

        // enable drop one cycle after a pop
        rx_base = rx.size(); pop_base = pops;
        load(3, 32'h400);
        enable = 1'b1;
        for (n = 0; n < 20 && !bus.fifo_pop; n++) @(negedge core_clk);
        step(1);
        enable = 1'b0;
        step(1);
        chk("s4_state_drain", 32'(dut.state), 32'd2);
        step(15);
        chk("s4_count", 32'(rx.size() - rx_base), 32'd1);
        chk("s4_word", (rx.size() > rx_base) ? rx[rx_base] : 32'hFFFF_FFFF, 32'h400);
        chk("s4_pops", 32'(pops - pop_base), 32'd1);
        chk("s4_state_idle", 32'(dut.state), 32'd0);
        chk("s4_busy", 32'(busy), 32'd0);
        fifo_q.delete();
        step(2);

        // empty FIFO with enable held
        pop_base = pops;
        vseen = 0;
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge core_clk);
            if (bus.out_valid) vseen++;
        end
        chk("s6_pops", 32'(pops - pop_base), 32'd0);
        chk("s6_valid", 32'(vseen), 32'd0);
        chk("s6_state_run", 32'(dut.state), 32'd1);
        enable = 1'b0;
        step(3);

        // reset mid-stream with 3 words buffered
        bus.out_ready = 1'b0;
        load(3, 32'h500);
        enable = 1'b1;
        step(20);
        chk("s5_pre_valid", 32'(bus.out_valid), 32'd1);
        chk("s5_pre_buf", 32'(dut.buf_count), 32'd3);
        resetn = 1'b0;
        #1;
        chk("s5_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("s5_rst_busy",  32'(busy),          32'd0);
        chk("s5_rst_data",  bus.out_data,       32'd0);
`ifdef BRAM_FIFO_READ_CTRL_STATS_EN
        chk("s5_rst_words_out", words_out, 32'd0);
`endif
        load(1, 32'h5AA);
        step(2);
        rx_base = rx.size();
        resetn = 1'b1;
        for (n = 0; n < 10 && !bus.fifo_pop; n++) @(negedge core_clk);
        chk("s5_pop_gap_ge2", 32'((n - 1) >= 2), 32'd1);
        bus.out_ready = 1'b1;
        step(12);
        chk("s5_count", 32'(rx.size() - rx_base), 32'd1);
        chk("s5_word", (rx.size() > rx_base) ? rx[rx_base] : 32'hFFFF_FFFF, 32'h5AA);
        enable = 1'b0;
        step(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
